// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence family: state encoding and default widths.
package seq_pkg;

   localparam int unsigned PAT_W_DEF = 8;
   localparam int unsigned LEN_W_DEF = 4;
   localparam int unsigned REP_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SEND = 2'b01,
      ST_DONE = 2'b10
   } seq_state_e;

   // Bit-index width for a pattern register of width w (at least one bit).
   function automatic int unsigned idx_w(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/seq_pattern_shifter.sv
// Pattern register with a down-counting bit index; exposes the bit that will be on the line next.
module seq_pattern_shifter
   import seq_pkg::*;
#(
   parameter int unsigned PAT_W = PAT_W_DEF,
   parameter int unsigned LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             advance_i,
   input  logic [PAT_W-1:0] pat_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             next_bit_c_o,
   output logic             last_c_o
);

   localparam int unsigned IDX_W = idx_w(PAT_W);

   logic [PAT_W-1:0] pat_q, pat_d;
   logic [IDX_W-1:0] top_q, top_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   // Without load or advance everything holds, which is how a pause freezes the index.
   always_comb begin
      pat_d = pat_q;
      top_d = top_q;
      idx_d = idx_q;
      if (load_i) begin
         pat_d = pat_i;
         top_d = IDX_W'(len_i - LEN_W'(1));
         idx_d = IDX_W'(len_i - LEN_W'(1));
      end else if (advance_i) begin
         idx_d = (idx_q == '0) ? top_q : idx_q - IDX_W'(1);
      end
   end

   assign next_bit_c_o = pat_d[idx_d];
   assign last_c_o     = (idx_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_q <= '0;
         top_q <= '0;
         idx_q <= '0;
      end else begin
         pat_q <= pat_d;
         top_q <= top_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/seq_pattern_tx.sv
// Bit-serial pattern transmitter: sends a latched pattern MSB-first for N repetitions or until stopped.
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int unsigned PAT_W = PAT_W_DEF,
   parameter int unsigned LEN_W = LEN_W_DEF,
   parameter int unsigned REP_W = REP_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             hold_i,
   input  logic [PAT_W-1:0] pat_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic [REP_W-1:0] rep_i,
   output logic             dout_o,
   output logic             dout_valid_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o
);

   seq_state_e       state_q, state_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic             counted_q, counted_d;
   logic             stop_pend_q, stop_pend_d;
   logic             dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic len_ok_c, stop_now_c, load_c, advance_c, finish_c;
   logic next_bit_c, last_c;

   assign len_ok_c   = (len_i != '0) && (len_i <= LEN_W'(PAT_W));
   assign stop_now_c = stop_pend_q | stop_i;
   assign load_c     = (state_q == ST_IDLE) && start_i && len_ok_c;
   // valid_q in SEND means the bit on the line this cycle has been delivered.
   assign advance_c  = (state_q == ST_SEND) && valid_q;
   assign finish_c   = advance_c && last_c &&
                       (stop_now_c || (counted_q && (rep_q == REP_W'(1))));

   seq_pattern_shifter #(
      .PAT_W (PAT_W),
      .LEN_W (LEN_W)
   ) u_shifter (
      .clk          (clk),
      .rst          (rst),
      .load_i       (load_c),
      .advance_i    (advance_c),
      .pat_i        (pat_i),
      .len_i        (len_i),
      .next_bit_c_o (next_bit_c),
      .last_c_o     (last_c)
   );

   // Next state and next-cycle outputs; outputs are registered from the next state.
   always_comb begin
      state_d     = state_q;
      rep_d       = rep_q;
      counted_d   = counted_q;
      stop_pend_d = stop_pend_q;
      dout_d      = dout_q;
      valid_d     = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (len_ok_c) begin
                  rep_d       = rep_i;
                  counted_d   = (rep_i != '0);
                  stop_pend_d = 1'b0;
                  state_d     = ST_SEND;
                  valid_d     = 1'b1;
                  dout_d      = next_bit_c;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_SEND: begin
            stop_pend_d = stop_now_c;
            if (advance_c && last_c && counted_q) begin
               rep_d = rep_q - REP_W'(1);
            end
            if (finish_c) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               dout_d  = 1'b0;
            end else if (!hold_i) begin
               valid_d = 1'b1;
               dout_d  = next_bit_c;
            end
         end
         ST_DONE: begin
            state_d     = ST_IDLE;
            stop_pend_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            dout_d  = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rep_q       <= '0;
         counted_q   <= 1'b0;
         stop_pend_q <= 1'b0;
         dout_q      <= 1'b0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rep_q       <= rep_d;
         counted_q   <= counted_d;
         stop_pend_q <= stop_pend_d;
         dout_q      <= dout_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign dout_o       = dout_q;
   assign dout_valid_o = valid_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: a stream-level model queues timed expected bits/done/err.
module tb_seq_pattern_tx;

   localparam int K_BIT  = 0;
   localparam int K_DONE = 1;
   localparam int K_ERR  = 2;

   typedef struct {
      int     kind;
      logic   val;
      longint cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, stop = 1'b0, hold = 1'b0;
   logic [7:0] pat_in = '0;
   logic [3:0] len_in = '0;
   logic [3:0] rep_in = '0;
   logic       dout, dout_valid, busy, done, err;

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   bit     exp_busy = 1'b0;
   exp_t   q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_pattern_tx dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .stop_i       (stop),
      .hold_i       (hold),
      .pat_i        (pat_in),
      .len_i        (len_in),
      .rep_i        (rep_in),
      .dout_o       (dout),
      .dout_valid_o (dout_valid),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err)
   );

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic pop_cmp(input int kind, input logic val);
      exp_t e;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_output: kind %0d at cycle %0d, required nothing", kind, cyc);
         return;
      end
      checks--;
      e = q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.cyc);
      if (kind == K_BIT) check("dout_bit", longint'(val), longint'(e.val));
   endtask

   // Monitor: every presented output must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         check("busy", longint'(busy), longint'(exp_busy));
         if (dout_valid) pop_cmp(K_BIT, dout);
         if (done) begin
            pop_cmp(K_DONE, 1'b0);
            check("dout_on_done", longint'(dout), 0);
         end
         if (err) pop_cmp(K_ERR, 1'b0);
      end
   end

   // Reference: the line carries the repeated pattern stream; a cycle carries a bit unless
   // hold was high the cycle before; the run ends after a full repetition once stop was seen
   // or the counted repetitions are used up, and done follows on the next cycle.
   task automatic do_run(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] rep,
                         input logic [63:0] hold_mask, input int hold_pct, input int stop_at,
                         input bit spam);
      logic rb[$];
      int   pos, reps_left, t;
      bit   stop_seen, prev_hold, fin, valid, h, s;
      for (int k = 0; k < int'(len); k++) rb.push_back(pat[int'(len) - 1 - k]);
      start  = 1'b1;
      pat_in = pat;
      len_in = len;
      rep_in = rep;
      hold   = 1'($urandom_range(0, 1));
      stop   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      pos = 0; reps_left = int'(rep); stop_seen = 0; prev_hold = 0; fin = 0; t = 1;
      while (!fin) begin
         exp_busy = 1'b1;
         valid = (t == 1) || !prev_hold;
         h = ((t < 64) && hold_mask[t]) || (int'($urandom_range(0, 99)) < hold_pct);
         s = (t == stop_at);
         start  = spam ? 1'($urandom_range(0, 1)) : 1'b0;
         pat_in = 8'($urandom);
         len_in = 4'($urandom);
         rep_in = 4'($urandom);
         hold   = h;
         stop   = s;
         stop_seen |= s;
         if (valid) begin
            q.push_back(exp_t'{K_BIT, rb[pos], cyc});
            if (pos < int'(len) - 1) pos++;
            else begin
               pos = 0;
               if (rep != 0) reps_left--;
               if (stop_seen || (rep != 0 && reps_left == 0)) fin = 1;
            end
         end
         prev_hold = h;
         @(posedge clk); #1;
         t++;
         if (t > 2000) begin
            check("run_length_bound", t, 2000);
            fin = 1;
         end
      end
      q.push_back(exp_t'{K_DONE, 1'b0, cyc});
      exp_busy = 1'b1;
      start    = spam ? 1'b1 : 1'b0;
      len_in   = 4'($urandom);
      hold     = 1'b0;
      stop     = 1'b0;
      @(posedge clk); #1;
      exp_busy = 1'b0;
      start    = 1'b0;
   endtask

   task automatic do_err(input logic [3:0] len);
      start  = 1'b1;
      len_in = len;
      pat_in = 8'($urandom);
      rep_in = 4'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      q.push_back(exp_t'{K_ERR, 1'b0, cyc});
      @(posedge clk); #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_dout"}, longint'(dout), 0);
      check({tag, "_valid"}, longint'(dout_valid), 0);
      check({tag, "_busy"}, longint'(busy), 0);
      check({tag, "_done"}, longint'(done), 0);
      check({tag, "_err"}, longint'(err), 0);
   endtask

   initial begin
      logic [7:0] rp;
      logic [3:0] rl, rr;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      check_outputs_zero("post_reset");

      do_run(8'h05, 4'd3, 4'd2, 64'h0, 0, 0, 1'b0);
      do_run(8'h0A, 4'd4, 4'd0, 64'h0, 0, 10, 1'b0);
      do_run(8'hB4, 4'd8, 4'd1, 64'h1C, 0, 0, 1'b0);
      do_err(4'd0);
      do_err(4'd9);
      do_err(4'd15);

      // Reset asserted in the middle of the 4th bit of an 8-bit run.
      start = 1'b1; pat_in = 8'hC3; len_in = 4'd8; rep_in = 4'd1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int t = 1; t <= 3; t++) begin
         exp_busy = 1'b1;
         q.push_back(exp_t'{K_BIT, pat_in[8 - t], cyc});
         @(posedge clk); #1;
      end
      #2;
      rst = 1'b1;
      exp_busy = 1'b0;
      #1;
      check_outputs_zero("async_reset");
      @(posedge clk); #1;
      rst = 1'b0;
      check("queue_after_reset", q.size(), 0);
      do_run(8'hC3, 4'd8, 4'd1, 64'h0, 0, 0, 1'b0);

      // Back-to-back runs with start spam during SEND and DONE.
      do_run(8'hA5, 4'd5, 4'd2, 64'h0, 0, 0, 1'b1);
      do_run(8'h3C, 4'd6, 4'd1, 64'h0, 0, 0, 1'b1);

      for (int n = 0; n < 40; n++) begin
         rp = 8'($urandom);
         rl = 4'($urandom_range(1, 8));
         rr = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) do_err(($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15)));
         do_run(rp, rl, rr, 64'h0, int'($urandom_range(0, 30)),
                (rr == 0) ? int'($urandom_range(1, 3 * int'(rl) + 4)) : 0, 1'b1);
      end

      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
